spi_multi_slave_master: RTL and testbench

- SPI bus master, mode 0 (CPOL=0, CPHA=0), full-duplex, one byte per transfer.
- Drives up to three slaves through individual active-low chip selects (cs0..cs2) and shares sclk/mosi among them.
- Sits between a system-side request interface (start/slave_sel/mosi_data → done/miso_data) and the external SPI pins.
- The system-level MISO mux, which selects the active slave's MISO, is outside this block.

---
 rtl/spi_multi_slave_master.sv | 154 +++++++++++++++
 tb/tb_spi_multi_slave_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_multi_slave_master.sv
// SPI mode-0 byte master driving three slaves through separate chip selects.
// Ports: clk/rst (async high), start/slave_sel/mosi_data request,
//   miso in; sclk/mosi/cs0..cs2 pins, done pulse and miso_data result out.
// Build option: define SPI_LSB_FIRST_EN to shift TX/RX LSB first.
module spi_multi_slave_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int HALF_PERIOD = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            slave_sel,
  input  logic [DATA_WIDTH-1:0] mosi_data,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  cs0,
  output logic                  cs1,
  output logic                  cs2,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] miso_data
);

  localparam int HCW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int PCW = $clog2(2 * DATA_WIDTH);
  localparam logic [HCW-1:0] HC_MAX = HCW'(HALF_PERIOD - 1);
  localparam logic [PCW-1:0] PH_MAX = PCW'(2 * DATA_WIDTH - 1);

  typedef logic [DATA_WIDTH-1:0] word_t;

`ifdef SPI_LSB_FIRST_EN
  localparam int FIRST = 0;
  // TX rotates so every bit stays live; wrapped bits are never driven.
  function automatic word_t tx_shift(input word_t v);
    return {v[0], v[DATA_WIDTH-1:1]};
  endfunction
  function automatic word_t rx_shift(input word_t v, input logic b);
    return {b, v[DATA_WIDTH-1:1]};
  endfunction
`else
  localparam int FIRST = DATA_WIDTH - 1;
  function automatic word_t tx_shift(input word_t v);
    return {v[DATA_WIDTH-2:0], v[DATA_WIDTH-1]};
  endfunction
  function automatic word_t rx_shift(input word_t v, input logic b);
    return {v[DATA_WIDTH-2:0], b};
  endfunction
`endif

  typedef enum logic [1:0] {
    IDLE, SETUP, TRANSFER, FINISH
  } state_t;

  state_t          state_q, state_d;
  word_t           tx_q, tx_d;
  word_t           rx_q, rx_d;
  word_t           miso_data_q, miso_data_d;
  logic [HCW-1:0]  half_q, half_d;
  logic [PCW-1:0]  phase_q, phase_d;
  logic            sclk_q, sclk_d;
  logic            mosi_q, mosi_d;
  logic [2:0]      cs_q, cs_d;
  logic            done_q, done_d;

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    miso_data_d = miso_data_q;
    half_d      = half_q;
    phase_d     = phase_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    cs_d        = cs_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Outputs are registered on entry so SETUP already shows
        // the selected cs low and the first data bit.
        if (start && slave_sel != 2'd3) begin
          state_d = SETUP;
          tx_d    = mosi_data;
          mosi_d  = mosi_data[FIRST];
          cs_d    = ~(3'b001 << slave_sel);
        end
      end
      SETUP: begin
        state_d = TRANSFER;
        half_d  = '0;
        phase_d = '0;
        sclk_d  = 1'b0;
      end
      TRANSFER: begin
        if (half_q != HC_MAX) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d  = '0;
          phase_d = phase_q + 1'b1;
          sclk_d  = ~sclk_q;
          if (!sclk_q) begin
            rx_d = rx_shift(rx_q, miso);
          end else begin
            tx_d   = tx_shift(tx_q);
            mosi_d = tx_d[FIRST];
            if (phase_q == PH_MAX) begin
              state_d     = FINISH;
              cs_d        = 3'b111;
              mosi_d      = 1'b0;
              done_d      = 1'b1;
              miso_data_d = rx_q;
            end
          end
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tx_q        <= '0;
      rx_q        <= '0;
      miso_data_q <= '0;
      half_q      <= '0;
      phase_q     <= '0;
      sclk_q      <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= 3'b111;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      miso_data_q <= miso_data_d;
      half_q      <= half_d;
      phase_q     <= phase_d;
      sclk_q      <= sclk_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
      done_q      <= done_d;
    end
  end

  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign cs0       = cs_q[0];
  assign cs1       = cs_q[1];
  assign cs2       = cs_q[2];
  assign done      = done_q;
  assign miso_data = miso_data_q;

endmodule

// File: tb/tb_spi_multi_slave_master.sv
// Bench for spi_multi_slave_master: three mode-0 slave models, scoreboard
// of expected byte exchanges, random and directed transfers.
module tb_spi_multi_slave_master;

`ifdef SPI_LSB_FIRST_EN
  localparam bit LSB = 1'b1;
`else
  localparam bit LSB = 1'b0;
`endif
  localparam int SB  = LSB ? 0 : 7;
  localparam int LAT = 2 + 2 * 8 * 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] slave_sel;
  logic [7:0] mosi_data;
  logic       miso;
  logic       sclk, mosi, cs0, cs1, cs2, done;
  logic [7:0] miso_data;

  spi_multi_slave_master #(
    .DATA_WIDTH (8),
    .HALF_PERIOD(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .slave_sel(slave_sel),
    .mosi_data(mosi_data),
    .miso     (miso),
    .sclk     (sclk),
    .mosi     (mosi),
    .cs0      (cs0),
    .cs1      (cs1),
    .cs2      (cs2),
    .done     (done),
    .miso_data(miso_data)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_slv
    logic [7:0] tx = 8'h00;
    logic [7:0] rx = 8'h00;
    logic [7:0] sh = 8'h00;
    logic so = 1'b0;
    logic csn_p = 1'b1;
    logic sclk_p = 1'b0;
    wire csn = (g == 0) ? cs0 : (g == 1) ? cs1 : cs2;
    always @(csn or sclk) begin
      if (csn_p && !csn) begin
        sh = tx;
        rx = 8'h00;
        so = sh[SB];
      end else if (!csn && sclk && !sclk_p) begin
        rx = LSB ? {mosi, rx[7:1]} : {rx[6:0], mosi};
      end else if (!csn && !sclk && sclk_p) begin
        sh = LSB ? {1'b0, sh[7:1]} : {sh[6:0], 1'b0};
        so = sh[SB];
      end
      csn_p = csn;
      sclk_p = sclk;
    end
  end

  assign miso = !cs0 ? g_slv[0].so :
                !cs1 ? g_slv[1].so :
                !cs2 ? g_slv[2].so : 1'b0;

  typedef struct {
    int         sel;
    logic [7:0] mdata;
    logic [7:0] stx;
    int         cyc;
    int         rise;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tot_rise = 0;
  int tot_done = 0;
  int tot_cslow = 0;
  int tot_bad = 0;
  logic sclk_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [7:0] slave_rx(input int s);
    case (s)
      0: return g_slv[0].rx;
      1: return g_slv[1].rx;
      default: return g_slv[2].rx;
    endcase
  endfunction

  task automatic set_tx(input int s, input logic [7:0] v);
    case (s)
      0: g_slv[0].tx = v;
      1: g_slv[1].tx = v;
      default: g_slv[2].tx = v;
    endcase
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor / scoreboard: samples on the falling clk edge.
  always @(negedge clk) begin
    int ncs;
    int low;
    exp_t e;
    if (rst) begin
      exp_q.delete();
      sclk_prev = 1'b0;
    end else begin
      if (sclk && !sclk_prev) tot_rise++;
      sclk_prev = sclk;
      ncs = int'(!cs0) + int'(!cs1) + int'(!cs2);
      if (ncs > 0) tot_cslow++;
      if (ncs > 1) tot_bad++;
      if (ncs == 0 && (sclk || mosi)) tot_bad++;
      if (ncs == 1 && exp_q.size() > 0) begin
        low = !cs0 ? 0 : !cs1 ? 1 : 2;
        if (low != exp_q[0].sel) tot_bad++;
      end
      if (done) begin
        tot_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1, expected none");
        end else begin
          e = exp_q.pop_front();
          check("miso_data", miso_data, e.stx);
          check("slave_rx", slave_rx(e.sel), e.mdata);
          check("latency", cyc - e.cyc, LAT);
          check("sclk_rises", tot_rise - e.rise, 8);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic xfer(input int s, input logic [7:0] md,
                      input logic [7:0] st, input bit mid);
    exp_t e;
    int d0;
    int n;
    set_tx(s, st);
    tick();
    e.sel = s;
    e.mdata = md;
    e.stx = st;
    e.cyc = cyc;
    e.rise = tot_rise;
    exp_q.push_back(e);
    d0 = tot_done;
    start = 1'b1;
    slave_sel = 2'(s);
    mosi_data = md;
    tick();
    start = 1'b0;
    slave_sel = 2'($urandom_range(0, 3));
    mosi_data = 8'($urandom);
    if (mid) begin
      repeat (10) tick();
      start = 1'b1;
      slave_sel = 2'((s + 1) % 3);
      mosi_data = ~md;
      tick();
      start = 1'b0;
    end
    n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    tick();
    check("done_count", tot_done - d0, 1);
    if (tot_done == d0) exp_q.delete();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not end");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, c0, d0, n;
    logic [7:0] m0;
    rst = 1'b1;
    start = 1'b0;
    slave_sel = 2'd0;
    mosi_data = 8'h00;
    repeat (3) tick();
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs", {cs2, cs1, cs0}, 3'b111);
    check("rst_done", done, 0);
    check("rst_miso_data", miso_data, 0);
    rst = 1'b0;
    repeat (2) tick();

    xfer(0, 8'h5A, 8'hA5, 0);
    xfer(1, 8'hC3, 8'h3C, 0);
    xfer(2, 8'h0F, 8'hF0, 0);
    xfer(1, 8'h96, 8'h69, 1);

    // Invalid slave select must leave everything untouched.
    tick();
    m0 = miso_data;
    r0 = tot_rise;
    c0 = tot_cslow;
    d0 = tot_done;
    start = 1'b1;
    slave_sel = 2'd3;
    mosi_data = 8'hFF;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("sel3_rises", tot_rise, r0);
    check("sel3_cs", tot_cslow, c0);
    check("sel3_done", tot_done, d0);
    check("sel3_miso_data", miso_data, m0);

    // Reset in the middle of a byte.
    set_tx(0, 8'hA5);
    tick();
    r0 = tot_rise;
    start = 1'b1;
    slave_sel = 2'd0;
    mosi_data = 8'h5A;
    tick();
    start = 1'b0;
    n = 0;
    while (tot_rise - r0 < 4 && n < 100) begin
      tick();
      n++;
    end
    check("rst_mid_rises", tot_rise - r0, 4);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_cs", {cs2, cs1, cs0}, 3'b111);
    check("rst_mid_done", done, 0);
    check("rst_mid_miso_data", miso_data, 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    xfer(0, 8'h5A, 8'hA5, 0);

`ifdef SPI_LSB_FIRST_EN
    xfer(0, 8'h01, 8'h80, 0);
`endif

    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      xfer($urandom_range(0, 2), 8'($urandom), 8'($urandom),
           $urandom_range(0, 3) == 0);
    end

    repeat (5) tick();
    check("protocol", tot_bad, 0);
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
